aesha_job_arbiter: RTL and testbench
====================================

Name: aesha_job_arbiter

Overview:
- Round-robin arbiter that shares one AESHA crypto core (AES-128 enc/dec or Keccak) between NUM_REQ independent requesters.
- Accepts one job at a time via per-requester valid/ready, drives the core's mode/key/data inputs plus a start pulse, and waits for core done.
- Returns the 512-bit result tagged with the requester ID on a single shared response channel.
- Includes a watchdog that aborts a hung core job and reports an error.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), requester ID width
- TIMEOUT_CYC, 1024, max cycles in RUN before abort (>= 2)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_req_valid  in  NUM_REQ  per-requester job request
- o_req_ready  out  NUM_REQ  one-hot accept, at most one bit set
- i_req_aes_or_keccak  in  NUM_REQ  per-requester mode
- i_req_enc_or_dec  in  NUM_REQ  per-requester direction
- i_req_key  in  NUM_REQ*128  per-requester key, requester k at [k*128 +: 128]
- i_req_data  in  NUM_REQ*512  per-requester data, requester k at [k*512 +: 512]
- o_core_aes_or_keccak  out  1  latched mode to core
- o_core_enc_or_dec  out  1  latched direction to core
- o_core_key  out  128  latched key to core
- o_core_data  out  512  latched data to core
- o_core_start  out  1  one-cycle job start
- o_core_abort  out  1  one-cycle core reset request on timeout
- i_core_done  in  1  core completion pulse
- i_core_data  in  512  core result, valid with i_core_done
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accept
- o_rsp_id  out  ID_W  requester ID of the response
- o_rsp_data  out  512  result data
- o_rsp_err  out  1  job aborted by watchdog
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (i_reset==0 at a clock edge): state=IDLE, rr_ptr=0, timer=0, all outputs 0, all latched core fields 0. Reset overrides any operation in flight; the job is dropped without a response.
- States: IDLE, START, RUN, RESP.
- IDLE:
  - grant = first k with i_req_valid[k], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - o_req_ready[grant]=1 combinationally, only in IDLE. The handshake completes in the same cycle.
  - On handshake: latch that requester's mode, dir, key, data and ID; set rr_ptr=(grant+1) mod NUM_REQ; go to START.
  - If no request is valid, stay in IDLE and keep rr_ptr unchanged.
- START: o_core_start=1 for exactly this cycle; timer=0; go to RUN.
- RUN:
  - timer increments each cycle.
  - i_core_done=1: latch i_core_data into o_rsp_data, o_rsp_err=0, go to RESP.
  - Otherwise, when timer reaches TIMEOUT_CYC-1: pulse o_core_abort for one cycle, o_rsp_data=0, o_rsp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins: no abort, err=0.
- RESP:
  - o_rsp_valid=1, with o_rsp_id/data/err held stable until i_rsp_ready.
  - On handshake go to IDLE; o_rsp_valid drops the next cycle.
  - No new request is accepted until the FSM returns to IDLE. One job is outstanding at most.
- Core inputs (o_core_*) stay stable from START until the next accept.
- i_core_done outside RUN is ignored.
- Minimum latency, accept to o_rsp_valid: accept at cycle t, start at t+1, done at earliest t+2, rsp_valid at t+3.
- Back-to-back: the earliest next accept is the cycle after the rsp handshake.

Decomposition:
- Shared package aesha_pkg:
  - AES_KEY_W=128, AESHA_DATA_W=512
  - typedef enum logic [1:0] {IDLE, START, RUN, RESP} arb_state_t
  - packed struct aesha_job_t {mode, dir, key, data}
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot grant and grant index plus any_req. Purely combinational; reused elsewhere.

Test Plan:
- Single job: req1 valid, AES enc, key=0x000102...0F, core done 5 cycles after start with data=0xA5 repeated -> o_req_ready=0b0010 for 1 cycle; o_core_start 1 cycle later; o_rsp_valid with id=1, data=0xA5..., err=0; rr_ptr=2.
- Fairness: all 4 requesters hold valid for 8 jobs, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; no requester granted twice before all others are served.
- Response backpressure: hold i_rsp_ready=0 for 10 cycles with req2 pending -> o_rsp_id/data stable; o_req_ready=0 throughout; req2 granted the cycle after rsp handshake.
- Watchdog: TIMEOUT_CYC=16, core never signals done -> o_core_abort pulses exactly 16 cycles after START; o_rsp_err=1, o_rsp_data=0.
- Done on the timeout boundary: done on the same cycle the timer reaches 15 -> err=0, no abort, data=core data.
- Reset mid-RUN: i_reset=0 for 1 cycle -> next cycle o_busy=0, o_rsp_valid=0; later done pulse ignored; rr_ptr=0, so req0 is granted first after reset.

Source files
------------

// File: rtl/aesha_pkg.sv
// Shared types and widths for the AESHA job arbiter slice.
package aesha_pkg;

  localparam int AES_KEY_W    = 128;
  localparam int AESHA_DATA_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    RESP
  } arb_state_t;

  // One job as presented to the crypto core.
  typedef struct packed {
    logic                    mode;
    logic                    dir;
    logic [AES_KEY_W-1:0]    key;
    logic [AESHA_DATA_W-1:0] data;
  } aesha_job_t;

endpackage

// File: rtl/aesha_job_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  // Scan N positions starting at ptr, wrapping modulo N; keep the first hit.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any_req && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aesha_job_arbiter.sv
// Round-robin job arbiter sharing one AESHA core between NUM_REQ requesters,
// with a watchdog that aborts a hung core job.
module aesha_job_arbiter
  import aesha_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0]              i_req_aes_or_keccak,
  input  logic [NUM_REQ-1:0]              i_req_enc_or_dec,
  input  logic [NUM_REQ*AES_KEY_W-1:0]    i_req_key,
  input  logic [NUM_REQ*AESHA_DATA_W-1:0] i_req_data,
  output logic                            o_core_aes_or_keccak,
  output logic                            o_core_enc_or_dec,
  output logic [AES_KEY_W-1:0]            o_core_key,
  output logic [AESHA_DATA_W-1:0]         o_core_data,
  output logic                            o_core_start,
  output logic                            o_core_abort,
  input  logic                            i_core_done,
  input  logic [AESHA_DATA_W-1:0]         i_core_data,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [ID_W-1:0]                 o_rsp_id,
  output logic [AESHA_DATA_W-1:0]         o_rsp_data,
  output logic                            o_rsp_err,
  output logic                            o_busy
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  arb_state_t              state, state_nxt;
  logic [ID_W-1:0]         rr_ptr;
  logic [TMR_W-1:0]        timer;
  aesha_job_t              job;
  logic [ID_W-1:0]         rsp_id;
  logic [AESHA_DATA_W-1:0] rsp_data;
  logic                    rsp_err;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [ID_W-1:0]         arb_idx;
  logic                    arb_any;
  logic                    accept;
  logic                    done_hit;
  logic                    timeout_hit;

  aesha_job_t              req_job [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_job[k] = {i_req_aes_or_keccak[k],
                         i_req_enc_or_dec[k],
                         i_req_key[k*AES_KEY_W +: AES_KEY_W],
                         i_req_data[k*AESHA_DATA_W +: AESHA_DATA_W]};
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the single-cycle handshake/start/abort strobes.
  always_comb begin
    state_nxt    = state;
    o_req_ready  = '0;
    o_core_start = 1'b0;
    o_core_abort = 1'b0;
    accept       = 1'b0;
    done_hit     = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          o_req_ready = arb_grant;
          accept      = 1'b1;
          state_nxt   = START;
        end
      end
      START: begin
        o_core_start = 1'b1;
        state_nxt    = RUN;
      end
      RUN: begin
        // A done arriving on the last allowed cycle beats the watchdog.
        if (i_core_done) begin
          done_hit  = 1'b1;
          state_nxt = RESP;
        end else if (timer == TMR_LAST) begin
          o_core_abort = 1'b1;
          timeout_hit  = 1'b1;
          state_nxt    = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, round-robin pointer, watchdog timer and response holding registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rr_ptr   <= '0;
      timer    <= '0;
      job      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        job    <= req_job[arb_idx];
        rsp_id <= arb_idx;
        rr_ptr <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
      end
      if (state == START)    timer <= '0;
      else if (state == RUN) timer <= timer + TMR_W'(1);
      if (done_hit) begin
        rsp_data <= i_core_data;
        rsp_err  <= 1'b0;
      end else if (timeout_hit) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  assign o_core_aes_or_keccak = job.mode;
  assign o_core_enc_or_dec    = job.dir;
  assign o_core_key           = job.key;
  assign o_core_data          = job.data;
  assign o_rsp_valid          = (state == RESP);
  assign o_rsp_id             = rsp_id;
  assign o_rsp_data           = rsp_data;
  assign o_rsp_err            = rsp_err;
  assign o_busy               = (state != IDLE);

endmodule

// File: tb/tb_aesha_job_arbiter.sv
// Self-checking bench for aesha_job_arbiter with a scoreboard of expected responses.
module tb_aesha_job_arbiter;
  import aesha_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 16;

  logic                            i_clk = 1'b0;
  logic                            i_reset;
  logic [NUM_REQ-1:0]              i_req_valid;
  logic [NUM_REQ-1:0]              o_req_ready;
  logic [NUM_REQ-1:0]              i_req_aes_or_keccak;
  logic [NUM_REQ-1:0]              i_req_enc_or_dec;
  logic [NUM_REQ*AES_KEY_W-1:0]    i_req_key;
  logic [NUM_REQ*AESHA_DATA_W-1:0] i_req_data;
  logic                            o_core_aes_or_keccak;
  logic                            o_core_enc_or_dec;
  logic [AES_KEY_W-1:0]            o_core_key;
  logic [AESHA_DATA_W-1:0]         o_core_data;
  logic                            o_core_start;
  logic                            o_core_abort;
  logic                            i_core_done;
  logic [AESHA_DATA_W-1:0]         i_core_data;
  logic                            o_rsp_valid;
  logic                            i_rsp_ready;
  logic [ID_W-1:0]                 o_rsp_id;
  logic [AESHA_DATA_W-1:0]         o_rsp_data;
  logic                            o_rsp_err;
  logic                            o_busy;

  aesha_job_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_req_valid          (i_req_valid),
    .o_req_ready          (o_req_ready),
    .i_req_aes_or_keccak  (i_req_aes_or_keccak),
    .i_req_enc_or_dec     (i_req_enc_or_dec),
    .i_req_key            (i_req_key),
    .i_req_data           (i_req_data),
    .o_core_aes_or_keccak (o_core_aes_or_keccak),
    .o_core_enc_or_dec    (o_core_enc_or_dec),
    .o_core_key           (o_core_key),
    .o_core_data          (o_core_data),
    .o_core_start         (o_core_start),
    .o_core_abort         (o_core_abort),
    .i_core_done          (i_core_done),
    .i_core_data          (i_core_data),
    .o_rsp_valid          (o_rsp_valid),
    .i_rsp_ready          (i_rsp_ready),
    .o_rsp_id             (o_rsp_id),
    .o_rsp_data           (o_rsp_data),
    .o_rsp_err            (o_rsp_err),
    .o_busy               (o_busy)
  );

  typedef struct {
    logic [ID_W-1:0]         id;
    logic [AESHA_DATA_W-1:0] data;
    logic                    err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [AES_KEY_W-1:0]    key_tab  [NUM_REQ];
  logic [AESHA_DATA_W-1:0] data_tab [NUM_REQ];
  localparam logic [NUM_REQ-1:0] MODE_TAB = 4'b1010;
  localparam logic [NUM_REQ-1:0] DIR_TAB  = 4'b0110;

  // Core model: fixed A5 pattern or the key replicated, after core_delay cycles.
  logic use_fixed        = 1'b1;
  int   core_delay       = 0;
  int   core_cnt         = 0;
  logic core_done_auto   = 1'b0;
  logic core_done_manual = 1'b0;

  assign i_core_data = use_fixed ? {64{8'hA5}} : {4{o_core_key}};
  assign i_core_done = core_done_auto | core_done_manual;

  initial forever #5 i_clk = ~i_clk;

  // Core responder: starts counting on the start cycle, pulses done core_delay cycles later.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      core_done_auto = 1'b0;
      if (core_cnt > 0) begin
        core_cnt = core_cnt - 1;
        if (core_cnt == 0) core_done_auto = 1'b1;
      end
      if (o_core_start && core_delay > 0) core_cnt = core_delay;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic wait_rsp(input int limit, output int cycles, output bit ok);
    cycles = 0;
    while (!o_rsp_valid && cycles < limit) begin
      step();
      cycles++;
    end
    ok = o_rsp_valid;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    step();
    total++;
    if ({o_busy, o_rsp_valid, o_core_start, o_core_abort, o_req_ready, o_rsp_err, o_rsp_id} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b vld=%b start=%b abort=%b rdy=%b err=%b id=%0d want all 0",
               o_busy, o_rsp_valid, o_core_start, o_core_abort, o_req_ready, o_rsp_err, o_rsp_id);
    end
    total++;
    if (o_core_key !== '0 || o_core_aes_or_keccak !== 1'b0 || o_core_enc_or_dec !== 1'b0) begin
      bad++;
      $display("FAIL reset_core: got key=%h mode=%b dir=%b want 0", o_core_key, o_core_aes_or_keccak, o_core_enc_or_dec);
    end
    total++;
    if (o_core_data !== '0 || o_rsp_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got core_data=%h rsp_data=%h want 0", o_core_data, o_rsp_data);
    end
    i_reset = 1'b1;
  endtask

  task automatic test_single_job();
    int   n;
    bit   ok;
    exp_t e;
    use_fixed   = 1'b1;
    core_delay  = 5;
    i_req_valid = 4'b0010;
    #1;
    total++;
    if (o_req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL single_grant: got ready=%b want 0010", o_req_ready);
    end
    sb.push_back('{id: 2'd1, data: {64{8'hA5}}, err: 1'b0});
    step();
    total++;
    if (o_core_start !== 1'b1 || o_req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL single_start: got start=%b ready=%b want 1 0000", o_core_start, o_req_ready);
    end
    total++;
    if (o_core_key !== key_tab[1] || o_core_data !== data_tab[1] ||
        o_core_aes_or_keccak !== MODE_TAB[1] || o_core_enc_or_dec !== DIR_TAB[1]) begin
      bad++;
      $display("FAIL single_latch: got key=%h mode=%b dir=%b want key=%h mode=%b dir=%b",
               o_core_key, o_core_aes_or_keccak, o_core_enc_or_dec, key_tab[1], MODE_TAB[1], DIR_TAB[1]);
    end
    i_req_valid = '0;
    wait_rsp(40, n, ok);
    total++;
    if (!ok || n != 6) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles (valid=%b) want 6", n, ok);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL single_sb: got empty scoreboard want one entry");
    end else begin
      e = sb.pop_front();
      if (o_rsp_id !== e.id || o_rsp_err !== e.err || o_rsp_data !== e.data) begin
        bad++;
        $display("FAIL single_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                 o_rsp_id, o_rsp_err, o_rsp_data, e.id, e.err, e.data);
      end
    end
    step();
    total++;
    if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got vld=%b busy=%b want 0 0", o_rsp_valid, o_busy);
    end
    i_req_valid = 4'b1111;
    #1;
    total++;
    if (o_req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL single_rrptr: got ready=%b want 0100", o_req_ready);
    end
    i_req_valid = '0;
  endtask

  task automatic test_fairness();
    int   w;
    int   n;
    int   k;
    bit   ok;
    exp_t e;
    i_reset = 1'b0;
    step();
    i_reset     = 1'b1;
    use_fixed   = 1'b0;
    core_delay  = 3;
    i_req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 8; j++) begin
      k = j % NUM_REQ;
      w = 0;
      while (o_req_ready == '0 && w < 20) begin
        step();
        w++;
      end
      total++;
      if (o_req_ready !== 4'(1 << k) || (j > 0 && w != 0)) begin
        bad++;
        $display("FAIL fair_grant%0d: got ready=%b wait=%0d want ready=%b wait=0", j, o_req_ready, w, 4'(1 << k));
      end
      sb.push_back('{id: ID_W'(k), data: {4{key_tab[k]}}, err: 1'b0});
      step();
      total++;
      if (o_core_key !== key_tab[k] || o_core_data !== data_tab[k] ||
          o_core_aes_or_keccak !== MODE_TAB[k] || o_core_enc_or_dec !== DIR_TAB[k]) begin
        bad++;
        $display("FAIL fair_latch%0d: got key=%h mode=%b dir=%b want key=%h mode=%b dir=%b", j,
                 o_core_key, o_core_aes_or_keccak, o_core_enc_or_dec, key_tab[k], MODE_TAB[k], DIR_TAB[k]);
      end
      wait_rsp(40, n, ok);
      total++;
      if (!ok || sb.size() == 0) begin
        bad++;
        $display("FAIL fair_rsp%0d: got valid=%b sb=%0d want valid=1 sb>0", j, ok, sb.size());
      end else begin
        e = sb.pop_front();
        if (o_rsp_id !== e.id || o_rsp_err !== e.err || o_rsp_data !== e.data) begin
          bad++;
          $display("FAIL fair_rsp%0d: got id=%0d err=%b data=%h want id=%0d err=%b data=%h", j,
                   o_rsp_id, o_rsp_err, o_rsp_data, e.id, e.err, e.data);
        end
      end
      step();
    end
    i_req_valid = '0;
  endtask

  task automatic test_backpressure();
    int   n;
    bit   ok;
    exp_t e;
    i_rsp_ready = 1'b0;
    core_delay  = 2;
    i_req_valid = 4'b0001;
    #1;
    total++;
    if (o_req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_grant0: got ready=%b want 0001", o_req_ready);
    end
    sb.push_back('{id: 2'd0, data: {4{key_tab[0]}}, err: 1'b0});
    step();
    i_req_valid = 4'b0100;
    wait_rsp(40, n, ok);
    e = sb[0];
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (o_rsp_valid !== 1'b1 || o_rsp_id !== e.id || o_rsp_data !== e.data ||
          o_rsp_err !== e.err || o_req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold%0d: got vld=%b id=%0d err=%b rdy=%b data=%h want vld=1 id=%0d err=%b rdy=0000 data=%h",
                 c, o_rsp_valid, o_rsp_id, o_rsp_err, o_req_ready, o_rsp_data, e.id, e.err, e.data);
      end
      step();
    end
    i_rsp_ready = 1'b1;
    #1;
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL bp_rsp0: got valid=%b sb=%0d want valid=1 sb>0", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (o_rsp_id !== e.id || o_rsp_err !== e.err || o_rsp_data !== e.data) begin
        bad++;
        $display("FAIL bp_rsp0: got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                 o_rsp_id, o_rsp_err, o_rsp_data, e.id, e.err, e.data);
      end
    end
    step();
    total++;
    if (o_req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_grant2: got ready=%b want 0100", o_req_ready);
    end
    sb.push_back('{id: 2'd2, data: {4{key_tab[2]}}, err: 1'b0});
    step();
    i_req_valid = '0;
    wait_rsp(40, n, ok);
    total++;
    if (!ok || sb.size() == 0) begin
      bad++;
      $display("FAIL bp_rsp2: got valid=%b sb=%0d want valid=1 sb>0", ok, sb.size());
    end else begin
      e = sb.pop_front();
      if (o_rsp_id !== e.id || o_rsp_err !== e.err || o_rsp_data !== e.data) begin
        bad++;
        $display("FAIL bp_rsp2: got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                 o_rsp_id, o_rsp_err, o_rsp_data, e.id, e.err, e.data);
      end
    end
    step();
  endtask

  task automatic test_watchdog();
    int   n;
    exp_t e;
    core_delay  = 0;
    i_req_valid = 4'b1000;
    #1;
    total++;
    if (o_req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL wd_grant: got ready=%b want 1000", o_req_ready);
    end
    sb.push_back('{id: 2'd3, data: '0, err: 1'b1});
    step();
    i_req_valid = '0;
    n = 0;
    while (!o_core_abort && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != TIMEOUT_CYC || o_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL wd_abort_time: got %0d cycles vld=%b want %0d vld=0", n, o_rsp_valid, TIMEOUT_CYC);
    end
    step();
    total++;
    if (o_core_abort !== 1'b0 || o_rsp_valid !== 1'b1 || sb.size() == 0) begin
      bad++;
      $display("FAIL wd_rsp: got abort=%b vld=%b sb=%0d want abort=0 vld=1 sb>0", o_core_abort, o_rsp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (o_rsp_id !== e.id || o_rsp_err !== e.err || o_rsp_data !== e.data) begin
        bad++;
        $display("FAIL wd_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                 o_rsp_id, o_rsp_err, o_rsp_data, e.id, e.err, e.data);
      end
    end
    step();
  endtask

  task automatic test_timeout_boundary();
    int   n;
    int   aborts;
    exp_t e;
    core_delay  = TIMEOUT_CYC;
    i_req_valid = 4'b0001;
    #1;
    total++;
    if (o_req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL edge_grant: got ready=%b want 0001", o_req_ready);
    end
    sb.push_back('{id: 2'd0, data: {4{key_tab[0]}}, err: 1'b0});
    step();
    i_req_valid = '0;
    n      = 0;
    aborts = 0;
    while (!o_rsp_valid && n < 40) begin
      if (o_core_abort) aborts++;
      step();
      n++;
    end
    total++;
    if (aborts != 0 || n != TIMEOUT_CYC + 1) begin
      bad++;
      $display("FAIL edge_done_wins: got aborts=%0d latency=%0d want aborts=0 latency=%0d", aborts, n, TIMEOUT_CYC + 1);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL edge_rsp: got empty scoreboard want one entry");
    end else begin
      e = sb.pop_front();
      if (o_rsp_id !== e.id || o_rsp_err !== e.err || o_rsp_data !== e.data) begin
        bad++;
        $display("FAIL edge_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h",
                 o_rsp_id, o_rsp_err, o_rsp_data, e.id, e.err, e.data);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    core_delay  = 0;
    i_req_valid = 4'b0010;
    #1;
    total++;
    if (o_req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL rmid_grant: got ready=%b want 0010", o_req_ready);
    end
    step();
    i_req_valid = '0;
    step();
    step();
    i_reset = 1'b0;
    step();
    i_reset = 1'b1;
    total++;
    if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_reset: got busy=%b vld=%b want 0 0", o_busy, o_rsp_valid);
    end
    core_done_manual = 1'b1;
    step();
    core_done_manual = 1'b0;
    step();
    total++;
    if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_late_done: got busy=%b vld=%b want 0 0", o_busy, o_rsp_valid);
    end
    i_req_valid = 4'b1111;
    #1;
    total++;
    if (o_req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_rrptr: got ready=%b want 0001", o_req_ready);
    end
    i_req_valid = '0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    key_tab[0]  = 128'h1F2E3D4C5B6A79881F2E3D4C5B6A7988;
    key_tab[1]  = 128'h000102030405060708090A0B0C0D0E0F;
    key_tab[2]  = 128'hC0FFEE00DEADBEEF0123456789ABCDEF;
    key_tab[3]  = 128'h55AA55AA33CC33CC0F0F0F0FF0F0F0F0;
    data_tab[0] = {8{64'h0123_4567_89AB_CDEF}};
    data_tab[1] = {16{32'h1111_2222}};
    data_tab[2] = {32{16'hBEEF}};
    data_tab[3] = {64{8'h3C}};
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_key[k*AES_KEY_W +: AES_KEY_W]        = key_tab[k];
      i_req_data[k*AESHA_DATA_W +: AESHA_DATA_W] = data_tab[k];
    end
    i_req_aes_or_keccak = MODE_TAB;
    i_req_enc_or_dec    = DIR_TAB;
    i_req_valid         = '0;
    i_rsp_ready         = 1'b1;
    i_reset             = 1'b0;
    step();

    test_reset();
    test_single_job();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_timeout_boundary();
    test_reset_mid_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
